// File: rtl/dtcm_arb_pkg.sv
// dtcm_arb_pkg: widths, port ids and lock-state encoding
// shared by the two-port dtcm arbiter.
package dtcm_arb_pkg;

  localparam int DEF_ADDR_W   = 9;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_BE_W     = DEF_DATA_W / 8;
  localparam int DEF_LOCK_MAX = 16;

  localparam logic PORT_M0 = 1'b0;
  localparam logic PORT_M1 = 1'b1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_state_e;

endpackage

// File: rtl/dtcm_arb_rr.sv
// dtcm_arb_rr: two-way round-robin pick plus the
// last-granted-port register.
module dtcm_arb_rr
  import dtcm_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == PORT_M1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (!rst_n) gnt = 2'b00;
    last_d = last_q;
    if (gnt[0]) last_d = PORT_M0;
    if (gnt[1]) last_d = PORT_M1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= PORT_M1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/dtcm_arbiter.sv
// dtcm_arbiter: shares one single-port dtcm between the CPU
// data port (m0) and the DMA port (m1), with RMW locking.
module dtcm_arbiter
  import dtcm_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BE_W     = DEF_BE_W,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [BE_W-1:0]   m0_be,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [BE_W-1:0]   m1_be,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_wr_en,
  output logic [BE_W-1:0]   ram_wr_byte_en,
  input  logic [DATA_W-1:0] ram_rd_data
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  lock_state_e      st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [1:0]       req_v;
  logic [1:0]       gnt;
  logic             rel0, rel1;

  // A lock owner masks the other port out of arbitration.
  always_comb begin
    req_v = {m1_req, m0_req};
    unique case (st_q)
      LOCKED0: req_v = {1'b0, m0_req};
      LOCKED1: req_v = {m1_req, 1'b0};
      default: req_v = {m1_req, m0_req};
    endcase
  end

  dtcm_arb_rr u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_v),
    .gnt   (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  assign rel0 = (cnt_q >= CNT_MAX)
             || (gnt[0] && !m0_lock)
             || (!m0_req && !m0_lock);
  assign rel1 = (cnt_q >= CNT_MAX)
             || (gnt[1] && !m1_lock)
             || (!m1_req && !m1_lock);

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      UNLOCKED: begin
        if (gnt[0] && m0_lock) begin
          st_d  = LOCKED0;
          cnt_d = CNT_W'(1);
        end else if (gnt[1] && m1_lock) begin
          st_d  = LOCKED1;
          cnt_d = CNT_W'(1);
        end
      end
      LOCKED0: begin
        if (rel0) begin
          st_d  = UNLOCKED;
          cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOCKED1: begin
        if (rel1) begin
          st_d  = UNLOCKED;
          cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        st_d  = UNLOCKED;
        cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    ram_addr       = '0;
    ram_wr_data    = '0;
    ram_wr_byte_en = '0;
    ram_wr_en      = 1'b0;
    if (gnt[0]) begin
      ram_addr       = m0_addr;
      ram_wr_data    = m0_wdata;
      ram_wr_byte_en = m0_be;
      ram_wr_en      = m0_we;
    end else if (gnt[1]) begin
      ram_addr       = m1_addr;
      ram_wr_data    = m1_wdata;
      ram_wr_byte_en = m1_be;
      ram_wr_en      = m1_we;
    end
  end

  assign rvalid_d = {gnt[1] & ~m1_we, gnt[0] & ~m0_we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= UNLOCKED;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = ram_rd_data;
  assign m1_rdata  = ram_rd_data;

endmodule
